// File: rtl/clq_fifo.sv
// ---------------------------------------------------------------------------
// clq_fifo : clause queue between the clause switch and the propagation engine
//
// Buffers clauses pushed by the switch (which cannot be back-pressured) and
// presents them to the engine in FIFO order over a valid/ready handshake.
// The head is first-word-fall-through. An almost-full level throttles the
// clause arbiter upstream. A push that cannot be stored is dropped and
// recorded in a sticky overflow flag.
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   sw2clq           clause from the switch
//   sw2clq_valid     push request; the switch is never stalled
//   flush            synchronous clear of all entries (overflow flag kept)
//   clq2eng          head clause, read combinationally from the storage array
//   clq2eng_valid    head entry valid (queue not empty)
//   eng2clq_ready    engine takes the head when high with clq2eng_valid
//   clq2carb_afull   occupancy >= AFULL_LVL, backpressure to the arbiter
//   clq_empty        occupancy == 0
//   clq_full         occupancy == DEPTH
//   clq_count        current occupancy
//   clq_ovf          sticky flag, set when a push is dropped; cleared by reset
// ---------------------------------------------------------------------------
package clq_pkg;
    // Clause word as carried by the switch fabric.
    typedef logic [31:0] cla_t;
endpackage

module clq_fifo
    import clq_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int AFULL_LVL = 14,
    parameter int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  cla_t             sw2clq,
    input  logic             sw2clq_valid,
    input  logic             flush,
    output cla_t             clq2eng,
    output logic             clq2eng_valid,
    input  logic             eng2clq_ready,
    output logic             clq2carb_afull,
    output logic             clq_empty,
    output logic             clq_full,
    output logic [CNT_W-1:0] clq_count,
    output logic             clq_ovf
);

    localparam int PTR_W = $clog2(DEPTH);

    cla_t             mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic pop;
    logic push_ok;
    logic drop;

    // Status is decoded from the registered count only, so none of these
    // outputs depend combinationally on the handshake inputs.
    assign clq_count      = count;
    assign clq_empty      = (count == '0);
    assign clq_full       = (count == CNT_W'(DEPTH));
    assign clq2carb_afull = (count >= CNT_W'(AFULL_LVL));
    assign clq2eng_valid  = !clq_empty;
    assign clq2eng        = mem[rd_ptr];

    assign pop     = clq2eng_valid & eng2clq_ready;
    // When full, a push still fits if the head leaves in the same cycle.
    assign push_ok = sw2clq_valid & (!clq_full | pop);
    assign drop    = sw2clq_valid & clq_full & !pop;

    // Control state: pointers, occupancy and overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            clq_ovf <= 1'b0;
        end else if (flush) begin
            // Flush overrides any same-cycle push/pop; a push discarded
            // by flush is not an overflow, so clq_ovf is left alone.
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push_ok) begin
                count <= count - 1'b1;
            end
            if (drop) begin
                clq_ovf <= 1'b1;
            end
        end
    end

    // Storage array carries no reset; its contents are only observed
    // through entries that were written after the last reset/flush.
    // On a full push+pop, wr_ptr == rd_ptr: the popped head is overwritten
    // at the same edge it is consumed, which is safe.
    always_ff @(posedge clk) begin
        if (!flush && push_ok) begin
            mem[wr_ptr] <= sw2clq;
        end
    end

endmodule
